// File: rtl/regfile_mp_sb_if.sv
// Purpose: bundles the write, read and scoreboard signals of the register file.
// Latency: n/a (wiring only).
// Backpressure: none; every request is accepted in the cycle it is presented.
interface regfile_mp_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   // write port 0
   logic              we0;
   logic [ADDR_W-1:0] waddr0;
   logic [DATA_W-1:0] wdata0;
   // write port 1 (wins over port 0 on an address collision)
   logic              we1;
   logic [ADDR_W-1:0] waddr1;
   logic [DATA_W-1:0] wdata1;
   // read ports
   logic [ADDR_W-1:0] raddr0;
   logic [ADDR_W-1:0] raddr1;
   logic [DATA_W-1:0] rdata0;
   logic [DATA_W-1:0] rdata1;
   // scoreboard
   logic              sb_set;
   logic [ADDR_W-1:0] sb_addr;
   logic              busy0;
   logic              busy1;

   // requester side: datapath / hazard unit
   modport master (
      output we0, waddr0, wdata0,
      output we1, waddr1, wdata1,
      output raddr0, raddr1,
      output sb_set, sb_addr,
      input  rdata0, rdata1, busy0, busy1
   );

   // register file side
   modport slave (
      input  we0, waddr0, wdata0,
      input  we1, waddr1, wdata1,
      input  raddr0, raddr1,
      input  sb_set, sb_addr,
      output rdata0, rdata1, busy0, busy1
   );
endinterface

// File: rtl/regfile_mp_sb.sv
// Purpose: 2R/2W register file with optional zero register, write bypass and pending scoreboard.
// Latency: reads are combinational; write->read 0 cycles with bypass, 1 without; sb_set->busy 1 cycle.
// Backpressure: none; writes and scoreboard sets always commit on the edge unless rst is high.
module regfile_mp_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic           clk,
   input  logic           rst,
   regfile_mp_sb_if.slave rf
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  pend_q;
   logic [DEPTH-1:0]  pend_d;

   // qualified requests: blocked during reset and, with a zero register, at entry 0
   logic wr0_en;
   logic wr1_en;
   logic sb_en;

   // per read port: zero-register hit and bypass hits from each write port
   logic zero_r0;
   logic zero_r1;
   logic byp0_r0;
   logic byp1_r0;
   logic byp0_r1;
   logic byp1_r1;

   // qualify write and scoreboard requests
   always_comb begin
      wr0_en = rf.we0 && !rst && !((ZERO_REG != 0) && (rf.waddr0 == '0));
      wr1_en = rf.we1 && !rst && !((ZERO_REG != 0) && (rf.waddr1 == '0));
      sb_en  = rf.sb_set && !rst && !((ZERO_REG != 0) && (rf.sb_addr == '0));
   end

   // next storage state: port 0 first, port 1 overwrites it on a collision
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (wr0_en) begin
         mem_d[rf.waddr0] = rf.wdata0;
      end
      if (wr1_en) begin
         mem_d[rf.waddr1] = rf.wdata1;
      end
   end

   // next pending state: retiring writes clear, a new producer sets last so it wins a race
   always_comb begin
      pend_d = pend_q;
      if (wr0_en) begin
         pend_d[rf.waddr0] = 1'b0;
      end
      if (wr1_en) begin
         pend_d[rf.waddr1] = 1'b0;
      end
      if (sb_en) begin
         pend_d[rf.sb_addr] = 1'b1;
      end
   end

   // storage and scoreboard registers with synchronous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         pend_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         pend_q <= pend_d;
      end
   end

   // read-side hit detection; wrN_en already excludes reset, so bypass is off during rst
   always_comb begin
      zero_r0 = (ZERO_REG != 0) && (rf.raddr0 == '0);
      zero_r1 = (ZERO_REG != 0) && (rf.raddr1 == '0);
      byp0_r0 = (BYPASS != 0) && wr0_en && (rf.waddr0 == rf.raddr0);
      byp1_r0 = (BYPASS != 0) && wr1_en && (rf.waddr1 == rf.raddr0);
      byp0_r1 = (BYPASS != 0) && wr0_en && (rf.waddr0 == rf.raddr1);
      byp1_r1 = (BYPASS != 0) && wr1_en && (rf.waddr1 == rf.raddr1);
   end

   // read port 0: zero register, then forwarded data (port 1 first), then the array
   always_comb begin
      rf.busy0 = 1'b0;
      if (zero_r0) begin
         rf.rdata0 = '0;
      end else if (byp1_r0) begin
         rf.rdata0 = rf.wdata1;
      end else if (byp0_r0) begin
         rf.rdata0 = rf.wdata0;
      end else begin
         rf.rdata0 = mem_q[rf.raddr0];
         rf.busy0  = pend_q[rf.raddr0];
      end
   end

   // read port 1: same priority as port 0
   always_comb begin
      rf.busy1 = 1'b0;
      if (zero_r1) begin
         rf.rdata1 = '0;
      end else if (byp1_r1) begin
         rf.rdata1 = rf.wdata1;
      end else if (byp0_r1) begin
         rf.rdata1 = rf.wdata0;
      end else begin
         rf.rdata1 = mem_q[rf.raddr1];
         rf.busy1  = pend_q[rf.raddr1];
      end
   end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised next-generation register file for the pipelined datapath.
- Storage is 2**ADDR_W words of DATA_W bits, with two asynchronous read ports and two synchronous write ports.
- Optional hardwired zero register and optional write-to-read bypass.
- A per-entry pending scoreboard lets the hazard unit stall on registers that still have an outstanding producer.

Parameters:
- DATA_W, 32: word width in bits.
- ADDR_W, 5: address width; depth is 2**ADDR_W.
- ZERO_REG, 1: 1 = entry 0 reads 0, ignores writes and is never pending.
- BYPASS, 1: 1 = same-cycle write data is forwarded to matching read ports.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous reset, active-high.
- we0, input, 1: write enable, port 0.
- waddr0, input, ADDR_W: write address, port 0.
- wdata0, input, DATA_W: write data, port 0.
- we1, input, 1: write enable, port 1; port 1 has priority over port 0.
- waddr1, input, ADDR_W: write address, port 1.
- wdata1, input, DATA_W: write data, port 1.
- raddr0, input, ADDR_W: read address, port 0.
- raddr1, input, ADDR_W: read address, port 1.
- rdata0, output, DATA_W: read data, port 0.
- rdata1, output, DATA_W: read data, port 1.
- sb_set, input, 1: mark an entry pending (producer issued).
- sb_addr, input, ADDR_W: entry to mark pending.
- busy0, output, 1: entry at raddr0 is pending.
- busy1, output, 1: entry at raddr1 is pending.

Behaviour:
- Reset:
  - rst high at a rising clk edge clears all entries to 0 and all pending bits to 0.
  - While rst is high, writes and sb_set are ignored and the bypass is disabled.
  - rdata and busy reflect the stored array, so from the cycle after the reset edge all outputs are 0.
- Writes:
  - Written on the rising edge when weN=1 and rst=0.
  - Both ports enabled with waddr0==waddr1: wdata1 is stored and wdata0 is dropped.
  - ZERO_REG=1: writes to address 0 are discarded.
- Reads:
  - Combinational, zero latency.
  - ZERO_REG=1 and raddrN==0: rdataN=0 regardless of any write.
  - BYPASS=1 and rst=0, when a write to raddrN is enabled this cycle: rdataN equals that write data, with port-1 priority.
  - BYPASS=0: rdataN shows the stored value; new data is visible the cycle after the write edge.
  - Both read ports may hit the same address or the same bypass source.
- Scoreboard, one bit per entry:
  - Set on the edge when sb_set=1 and rst=0.
  - Cleared on the edge when either write port writes that entry.
  - sb_set and a clearing write to the same entry in the same cycle: set wins, because the new producer supersedes the retiring one.
  - ZERO_REG=1: sb_set to entry 0 is ignored.
  - Clearing is by address only; no write-ID tracking.
- Busy outputs:
  - busyN = pending[raddrN].
  - BYPASS=1 and an enabled write to raddrN this cycle: busyN=0, since the data is forwarded.
  - ZERO_REG=1 and raddrN==0: busyN=0.
- Latency:
  - Write to read is 0 cycles with BYPASS, 1 cycle without.
  - sb_set to busy is 1 cycle.
- Out-of-range addresses cannot occur, because the depth equals 2**ADDR_W.

Test Plan:
- Reset: write 0xDEADBEEF to entry 7, then pulse rst for one cycle → rdata0 at raddr0=7 reads 0x0 and busy0=0 the cycle after; a we0 asserted during rst does not commit.
- Dual-write collision: we0=we1=1, waddr0=waddr1=3, wdata0=0x11, wdata1=0x22 → entry 3 reads 0x22 next cycle; same cycle with BYPASS=1, rdata0 at raddr0=3 is 0x22.
- Zero register: we0=1, waddr0=0, wdata0=0xFFFFFFFF; sb_set=1, sb_addr=0 → rdata0=0 and busy0=0 on both the same and the following cycle (ZERO_REG=1).
- Bypass off (BYPASS=0): write 0x5A5A to entry 9 with raddr0=9 → rdata0 shows the old value 0 in the write cycle and 0x5A5A the next cycle.
- Scoreboard: sb_set to entry 4 → busy1 (raddr1=4) is 1 the next cycle and stays 1 until we1 writes entry 4. In the write cycle, busy1=0 and rdata1 equals the write data (BYPASS=1). Pending is clear after the edge.
- Set/clear race: with entry 6 pending, apply sb_set to 6 and we0 to 6 (data 0x77) together → entry 6 stays pending, stored value becomes 0x77, and busy0=1 at raddr0=6 on the next cycle.
